// File: rtl/wb_copy_master_if.sv
// Command handshake plus Wishbone classic bus bundle for wb_copy_master.
// The fill-mode command fields exist only when WB_COPY_FILL_EN is defined.
interface wb_copy_master_if;
    // Command handshake: a command transfers on a rising clock edge where
    // cmd_valid_i && cmd_ready_o; fields must be stable while cmd_valid_i is high.
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [29:0] cmd_src_i;
    logic [29:0] cmd_dst_i;
    logic [15:0] cmd_len_i;
`ifdef WB_COPY_FILL_EN
    logic        cmd_fill_i;
    logic [31:0] cmd_pattern_i;
`endif
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i, wb_dat_i, wb_ack_i,
        output cmd_ready_o, busy_o, done_o, err_o,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
`ifdef WB_COPY_FILL_EN
        , input cmd_fill_i, cmd_pattern_i
`endif
    );

    modport slave (
        output cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i, wb_dat_i, wb_ack_i,
        input  cmd_ready_o, busy_o, done_o, err_o,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
`ifdef WB_COPY_FILL_EN
        , output cmd_fill_i, cmd_pattern_i
`endif
    );
endinterface

// File: rtl/wb_copy_master.sv
// Wishbone classic block copy engine: one read then one write per word.
// Optional fill mode (pattern writes only) is enabled by WB_COPY_FILL_EN.
module wb_copy_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_copy_master_if.master bus,
    output logic [1:0]       dbg_state_o
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

    state_t        state_q, state_d;
    logic [29:0]   src_q, src_d;
    logic [29:0]   dst_q, dst_d;
    logic [29:0]   adr_q, adr_d;
    logic [15:0]   rem_q, rem_d;
    logic [31:0]   dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fill_q, fill_d;
    logic          cmd_fill;
    logic [31:0]   cmd_pattern;
    logic          timed_out;

`ifdef WB_COPY_FILL_EN
    assign cmd_fill    = bus.cmd_fill_i;
    assign cmd_pattern = bus.cmd_pattern_i;
`else
    assign cmd_fill    = 1'b0;
    assign cmd_pattern = '0;
`endif

    // Abort on the edge that ends the TIMEOUT-th un-acked strobe cycle.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        busy_d  = busy_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    src_d  = bus.cmd_src_i;
                    dst_d  = bus.cmd_dst_i;
                    rem_d  = bus.cmd_len_i;
                    fill_d = cmd_fill;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (bus.cmd_len_i == 16'd0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else if (cmd_fill) begin
                        state_d = WR;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        adr_d   = bus.cmd_dst_i;
                        dat_d   = cmd_pattern;
                    end else begin
                        state_d = RD;
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        adr_d   = bus.cmd_src_i;
                    end
                end
            end
            RD, WR: begin
                if (bus.wb_ack_i) begin
                    cnt_d = '0;
                    if (state_q == RD) begin
                        dat_d   = bus.wb_dat_i;
                        src_d   = src_q + 30'd1;
                        state_d = WR;
                        we_d    = 1'b1;
                        adr_d   = dst_q;
                    end else begin
                        dst_d = dst_q + 30'd1;
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_d = FIN;
                            cyc_d   = 1'b0;
                            we_d    = 1'b0;
                            done_d  = 1'b1;
                        end else if (fill_q) begin
                            adr_d = dst_q + 30'd1;
                        end else begin
                            // src_q was already advanced on the read ack.
                            state_d = RD;
                            we_d    = 1'b0;
                            adr_d   = src_q;
                        end
                    end
                end else if (timed_out) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            adr_q   <= '0;
            rem_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    // stb and cyc coincide: single accesses only, cyc held across the block.
    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_sel_o    = 4'hF;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign dbg_state_o     = state_q;
endmodule
